// File: rtl/pod_power_pkg.sv
// Shared definitions for the pod power sequencer: FSM state encoding and
// default timing constants for a 125 MHz clk_125mhz.
package pod_power_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_INPUT = 3'd1,
        RAMP       = 3'd2,
        SETTLE     = 3'd3,
        UP         = 3'd4,
        DOWN       = 3'd5,
        FAULT      = 3'd6
    } pod_state_e;

    localparam int unsigned DEF_NUM_RAILS      = 32'd3;
    localparam int unsigned DEF_STARTUP_CYCLES = 32'd62500000; // 500 ms
    localparam int unsigned DEF_PG_TIMEOUT     = 32'd1250000;  // 10 ms
    localparam int unsigned DEF_SETTLE_CYCLES  = 32'd125000;   // 1 ms
    localparam int unsigned DEF_FILTER_LEN     = 32'd16;

    // Largest of three cycle parameters; sizes the shared state counter.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/rail_pg_filter.sv
// Glitch filter for one rail power-good. A rise passes on the next edge;
// a drop is only accepted after FILTER_LEN consecutive low samples.
// Output resets low.
module rail_pg_filter
    import pod_power_pkg::*;
#(
    parameter int unsigned FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clk_125mhz,
    input  logic rst_n,
    input  logic pg_in,
    output logic pg_out
);

    localparam int unsigned CNT_W = (FILTER_LEN > 32'd1) ? $clog2(FILTER_LEN + 32'd1) : 32'd1;
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(FILTER_LEN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(FILTER_LEN - 32'd1);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    logic [CNT_W-1:0] low_cnt_r;
    logic             pg_r;

    // Saturating count of consecutive low samples; drop accepted at the limit.
    always_ff @(posedge clk_125mhz) begin
        if (!rst_n) begin
            low_cnt_r <= {CNT_W{1'b0}};
            pg_r      <= 1'b0;
        end else if (pg_in) begin
            low_cnt_r <= {CNT_W{1'b0}};
            pg_r      <= 1'b1;
        end else begin
            if (low_cnt_r != LEN_C) begin
                low_cnt_r <= low_cnt_r + ONE_C;
            end
            if (low_cnt_r >= LAST_C) begin
                pg_r <= 1'b0;
            end
        end
    end

    assign pg_out = pg_r;

endmodule

// File: rtl/pod_power_sequencer.sv
// Pod-side power sequencer: waits for stable host power, ramps local rails
// in order with per-rail power-good timeout, monitors enabled rails, reports
// faults on the active-low host fault line and sequences down on request.
// Define POD_PG_FILTER_EN to glitch-filter every rail_pg input.
module pod_power_sequencer
    import pod_power_pkg::*;
#(
    parameter int unsigned NUM_RAILS      = DEF_NUM_RAILS,
    parameter int unsigned STARTUP_CYCLES = DEF_STARTUP_CYCLES,
    parameter int unsigned PG_TIMEOUT     = DEF_PG_TIMEOUT,
    parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int unsigned FILTER_LEN     = DEF_FILTER_LEN,
    localparam int unsigned IDX_W         = (NUM_RAILS > 32'd1) ? $clog2(NUM_RAILS) : 32'd1
) (
    input  logic                 clk_125mhz,
    input  logic                 rst_n,
    input  logic                 host_pwr_good,
    input  logic                 sw_enable,
    input  logic [NUM_RAILS-1:0] rail_pg,
    output logic [NUM_RAILS-1:0] rail_en,
    output logic                 fault_n,
    output logic                 pod_ready,
    output logic [IDX_W-1:0]     fault_rail
);

    localparam int unsigned MAX_CYC = max3(STARTUP_CYCLES, PG_TIMEOUT, SETTLE_CYCLES);
    localparam int unsigned CNT_W   = (MAX_CYC > 32'd1) ? $clog2(MAX_CYC) : 32'd1;

    localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] PG_LAST      = CNT_W'(PG_TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO     = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] LAST_RAIL    = IDX_W'(NUM_RAILS - 32'd1);

    pod_state_e           state_r;
    logic [CNT_W-1:0]     count_r;
    logic [IDX_W-1:0]     idx_r;
    logic [NUM_RAILS-1:0] rail_en_r;
    logic                 fault_n_r;
    logic                 pod_ready_r;
    logic [IDX_W-1:0]     fault_rail_r;

    logic [NUM_RAILS-1:0] pg_s;
    logic [NUM_RAILS-1:0] idx_onehot_s;
    logic [NUM_RAILS-1:0] mon_mask_s;
    logic [NUM_RAILS-1:0] drop_s;
    logic                 drop_any_s;
    logic [IDX_W-1:0]     drop_idx_s;
    logic [IDX_W-1:0]     next_idx_s;
    logic [IDX_W-1:0]     prev_idx_s;

    // Lowest set bit index, so simultaneous drops report the earliest rail.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_RAILS-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int j = NUM_RAILS - 1; j >= 0; j--) begin
            if (vec[j]) idx = IDX_W'(j);
        end
        return idx;
    endfunction

`ifdef POD_PG_FILTER_EN
    for (genvar g = 0; g < NUM_RAILS; g++) begin : g_pg_filter
        rail_pg_filter #(
            .FILTER_LEN (FILTER_LEN)
        ) u_filter (
            .clk_125mhz (clk_125mhz),
            .rst_n      (rst_n),
            .pg_in      (rail_pg[g]),
            .pg_out     (pg_s[g])
        );
    end
`else
    assign pg_s = rail_pg;
`endif

    assign next_idx_s = idx_r + IDX_ONE;
    assign prev_idx_s = idx_r - IDX_ONE;

    // Decode the rail currently ramping; it is not monitored until it is good.
    always_comb begin
        idx_onehot_s = {NUM_RAILS{1'b0}};
        for (int j = 0; j < NUM_RAILS; j++) begin
            idx_onehot_s[j] = (idx_r == IDX_W'(j));
        end
    end

    // Select which enabled rails are supervised in the current state.
    always_comb begin
        mon_mask_s = {NUM_RAILS{1'b0}};
        if (state_r == RAMP) begin
            mon_mask_s = rail_en_r & ~idx_onehot_s;
        end else if ((state_r == SETTLE) || (state_r == UP)) begin
            mon_mask_s = rail_en_r;
        end else begin
            mon_mask_s = {NUM_RAILS{1'b0}};
        end
    end

    assign drop_s     = mon_mask_s & ~pg_s;
    assign drop_any_s = |drop_s;
    assign drop_idx_s = lowest_set(drop_s);

    // Sequencer FSM with registered outputs; host loss beats faults, faults beat sw_enable.
    always_ff @(posedge clk_125mhz) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            count_r      <= {CNT_W{1'b0}};
            idx_r        <= IDX_ZERO;
            rail_en_r    <= {NUM_RAILS{1'b0}};
            fault_n_r    <= 1'b1;
            pod_ready_r  <= 1'b0;
            fault_rail_r <= IDX_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    count_r      <= {CNT_W{1'b0}};
                    idx_r        <= IDX_ZERO;
                    rail_en_r    <= {NUM_RAILS{1'b0}};
                    fault_n_r    <= 1'b1;
                    pod_ready_r  <= 1'b0;
                    fault_rail_r <= IDX_ZERO;
                    if (host_pwr_good && sw_enable) begin
                        state_r <= WAIT_INPUT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT_INPUT: begin
                    if (!host_pwr_good) begin
                        state_r <= IDLE;
                        count_r <= {CNT_W{1'b0}};
                    end else if (count_r == STARTUP_LAST) begin
                        state_r      <= RAMP;
                        count_r      <= {CNT_W{1'b0}};
                        idx_r        <= IDX_ZERO;
                        rail_en_r[0] <= 1'b1;
                    end else begin
                        count_r <= count_r + CNT_ONE;
                    end
                end
                RAMP: begin
                    if (!host_pwr_good) begin
                        state_r     <= IDLE;
                        count_r     <= {CNT_W{1'b0}};
                        idx_r       <= IDX_ZERO;
                        rail_en_r   <= {NUM_RAILS{1'b0}};
                        pod_ready_r <= 1'b0;
                    end else if (drop_any_s) begin
                        state_r      <= FAULT;
                        count_r      <= {CNT_W{1'b0}};
                        rail_en_r    <= {NUM_RAILS{1'b0}};
                        fault_n_r    <= 1'b0;
                        pod_ready_r  <= 1'b0;
                        fault_rail_r <= drop_idx_s;
                    end else if (pg_s[idx_r]) begin
                        state_r <= SETTLE;
                        count_r <= {CNT_W{1'b0}};
                    end else if (count_r == PG_LAST) begin
                        state_r      <= FAULT;
                        count_r      <= {CNT_W{1'b0}};
                        rail_en_r    <= {NUM_RAILS{1'b0}};
                        fault_n_r    <= 1'b0;
                        pod_ready_r  <= 1'b0;
                        fault_rail_r <= idx_r;
                    end else begin
                        count_r <= count_r + CNT_ONE;
                    end
                end
                SETTLE: begin
                    if (!host_pwr_good) begin
                        state_r     <= IDLE;
                        count_r     <= {CNT_W{1'b0}};
                        idx_r       <= IDX_ZERO;
                        rail_en_r   <= {NUM_RAILS{1'b0}};
                        pod_ready_r <= 1'b0;
                    end else if (drop_any_s) begin
                        state_r      <= FAULT;
                        count_r      <= {CNT_W{1'b0}};
                        rail_en_r    <= {NUM_RAILS{1'b0}};
                        fault_n_r    <= 1'b0;
                        pod_ready_r  <= 1'b0;
                        fault_rail_r <= drop_idx_s;
                    end else if (count_r == SETTLE_LAST) begin
                        count_r <= {CNT_W{1'b0}};
                        if (idx_r == LAST_RAIL) begin
                            state_r     <= UP;
                            pod_ready_r <= 1'b1;
                        end else begin
                            state_r               <= RAMP;
                            idx_r                 <= next_idx_s;
                            rail_en_r[next_idx_s] <= 1'b1;
                        end
                    end else begin
                        count_r <= count_r + CNT_ONE;
                    end
                end
                UP: begin
                    if (!host_pwr_good) begin
                        state_r     <= IDLE;
                        count_r     <= {CNT_W{1'b0}};
                        idx_r       <= IDX_ZERO;
                        rail_en_r   <= {NUM_RAILS{1'b0}};
                        pod_ready_r <= 1'b0;
                    end else if (drop_any_s) begin
                        state_r      <= FAULT;
                        count_r      <= {CNT_W{1'b0}};
                        rail_en_r    <= {NUM_RAILS{1'b0}};
                        fault_n_r    <= 1'b0;
                        pod_ready_r  <= 1'b0;
                        fault_rail_r <= drop_idx_s;
                    end else if (!sw_enable) begin
                        // First rail drops on the entry edge of the shutdown.
                        count_r          <= {CNT_W{1'b0}};
                        pod_ready_r      <= 1'b0;
                        rail_en_r[idx_r] <= 1'b0;
                        if (idx_r == IDX_ZERO) begin
                            state_r <= IDLE;
                        end else begin
                            state_r <= DOWN;
                            idx_r   <= prev_idx_s;
                        end
                    end else begin
                        state_r <= UP;
                    end
                end
                DOWN: begin
                    if (!host_pwr_good) begin
                        state_r     <= IDLE;
                        count_r     <= {CNT_W{1'b0}};
                        idx_r       <= IDX_ZERO;
                        rail_en_r   <= {NUM_RAILS{1'b0}};
                        pod_ready_r <= 1'b0;
                    end else if (count_r == SETTLE_LAST) begin
                        count_r          <= {CNT_W{1'b0}};
                        rail_en_r[idx_r] <= 1'b0;
                        if (idx_r == IDX_ZERO) begin
                            state_r <= IDLE;
                        end else begin
                            idx_r <= prev_idx_s;
                        end
                    end else begin
                        count_r <= count_r + CNT_ONE;
                    end
                end
                FAULT: begin
                    rail_en_r   <= {NUM_RAILS{1'b0}};
                    pod_ready_r <= 1'b0;
                    if (!host_pwr_good) begin
                        state_r      <= IDLE;
                        fault_n_r    <= 1'b1;
                        fault_rail_r <= IDX_ZERO;
                        idx_r        <= IDX_ZERO;
                    end else begin
                        state_r   <= FAULT;
                        fault_n_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    count_r      <= {CNT_W{1'b0}};
                    idx_r        <= IDX_ZERO;
                    rail_en_r    <= {NUM_RAILS{1'b0}};
                    fault_n_r    <= 1'b1;
                    pod_ready_r  <= 1'b0;
                    fault_rail_r <= IDX_ZERO;
                end
            endcase
        end
    end

    assign rail_en    = rail_en_r;
    assign fault_n    = fault_n_r;
    assign pod_ready  = pod_ready_r;
    assign fault_rail = fault_rail_r;

endmodule

// File: tb/tb_pod_power_sequencer.sv
// Self-checking bench for pod_power_sequencer. Regulators are modelled as
// plants whose power-good follows the enable after a random latency; expected
// output times come from timeline arithmetic over the sequencing rules.
module tb_pod_power_sequencer;

    localparam int NR = 3;
    localparam int ST = 50;
    localparam int TO = 100;
    localparam int SC = 10;
    localparam int FL = 4;
`ifdef POD_PG_FILTER_EN
    localparam int FD = 1;   // extra edge for a rise through the filter
    localparam int GD = FL;  // extra edges before a drop is accepted
`else
    localparam int FD = 0;
    localparam int GD = 0;
`endif

    logic          clk_125mhz = 1'b0;
    logic          rst_n;
    logic          host_pwr_good;
    logic          sw_enable;
    logic [NR-1:0] rail_pg;
    logic [NR-1:0] rail_en;
    logic          fault_n;
    logic          pod_ready;
    logic [1:0]    fault_rail;

    int cyc;
    int n_checks;
    int n_errors;
    int lat [NR];
    int age [NR];
    bit blocked [NR];
    int glitch_left [NR];

    pod_power_sequencer #(
        .NUM_RAILS      (NR),
        .STARTUP_CYCLES (ST),
        .PG_TIMEOUT     (TO),
        .SETTLE_CYCLES  (SC),
        .FILTER_LEN     (FL)
    ) dut (
        .clk_125mhz    (clk_125mhz),
        .rst_n         (rst_n),
        .host_pwr_good (host_pwr_good),
        .sw_enable     (sw_enable),
        .rail_pg       (rail_pg),
        .rail_en       (rail_en),
        .fault_n       (fault_n),
        .pod_ready     (pod_ready),
        .fault_rail    (fault_rail)
    );

    always #4 clk_125mhz = ~clk_125mhz;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // One clock: sample after the edge, then update the regulator plants.
    task automatic step();
        @(posedge clk_125mhz);
        #1;
        cyc++;
        for (int k = 0; k < NR; k++) begin
            if (rail_en[k]) age[k] = (age[k] < 0) ? 0 : age[k] + 1;
            else age[k] = -1;
            if (glitch_left[k] > 0) glitch_left[k]--;
            rail_pg[k] = (age[k] >= 0) && (age[k] >= lat[k]) && !blocked[k] && (glitch_left[k] == 0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; host_pwr_good = 1'b0; sw_enable = 1'b0;
        for (int k = 0; k < NR; k++) begin
            blocked[k] = 1'b0; glitch_left[k] = 0; lat[k] = $urandom_range(0, 30);
        end
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    function automatic logic [NR-1:0] low_mask(input int n);
        return NR'((1 << n) - 1);
    endfunction

    // Bring-up from WAIT entry at wait_edge; checks each enable step and pod_ready timing.
    task automatic bring_up(input int wait_edge, input int upto);
        int te [NR];
        int e, t_ready, last;
        bit fault_seen;
        e = wait_edge + ST;
        for (int k = 0; k < upto; k++) begin
            te[k] = e;
            e = e + lat[k] + 1 + FD + SC;
        end
        t_ready = (upto == NR) ? e : -10;
        last    = (upto == NR) ? e : te[upto-1];
        fault_seen = 1'b0;
        while (cyc < last) begin
            step();
            if (!fault_n) fault_seen = 1'b1;
            for (int k = 0; k < upto; k++) begin
                if (cyc == te[k] - 1) begin
                    n_checks++;
                    if (rail_en !== low_mask(k)) begin
                        n_errors++;
                        $display("FAIL rail_en_before_step%0d cyc=%0d: got %b expected %b", k, cyc, rail_en, low_mask(k));
                    end
                end
                if (cyc == te[k]) begin
                    n_checks++;
                    if (rail_en !== low_mask(k + 1)) begin
                        n_errors++;
                        $display("FAIL rail_en_step%0d cyc=%0d: got %b expected %b", k, cyc, rail_en, low_mask(k + 1));
                    end
                end
            end
            if (cyc == t_ready - 1) begin
                n_checks++;
                if (pod_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL pod_ready_early cyc=%0d: got %b expected 0", cyc, pod_ready);
                end
            end
            if (cyc == t_ready) begin
                n_checks++;
                if (pod_ready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL pod_ready_up cyc=%0d: got %b expected 1", cyc, pod_ready);
                end
            end
        end
        n_checks++;
        if (fault_seen !== 1'b0) begin
            n_errors++;
            $display("FAIL bringup_fault_n: fault_n went low during bring-up, expected stay 1");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; host_pwr_good = 1'b1; sw_enable = 1'b1;
        for (int k = 0; k < NR; k++) begin
            age[k] = -1; blocked[k] = 1'b0; glitch_left[k] = 0; lat[k] = 5;
        end
        rail_pg = '0;
        step(); step();
        n_checks++;
        if ({rail_en, fault_n, pod_ready, fault_rail} !== {3'b000, 1'b1, 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL reset_values: got en=%b fn=%b rdy=%b fr=%0d expected en=000 fn=1 rdy=0 fr=0",
                     rail_en, fault_n, pod_ready, fault_rail);
        end
        // Fixed 5-cycle latencies: the nominal 001/011/111 sequence.
        rst_n = 1'b1;
        bring_up(cyc + 1, NR);
    endtask

    task automatic test_nominal();
        for (int it = 0; it < 3; it++) begin
            bit lost;
            do_reset();
            host_pwr_good = 1'b1; sw_enable = 1'b1;
            bring_up(cyc + 1, NR);
            lost = 1'b0;
            repeat (20) begin
                step();
                if (!pod_ready || !fault_n || rail_en !== 3'b111) lost = 1'b1;
            end
            n_checks++;
            if (lost !== 1'b0) begin
                n_errors++;
                $display("FAIL nominal_hold it=%0d: UP state not held, en=%b rdy=%b fn=%b", it, rail_en, pod_ready, fault_n);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        blocked[1] = 1'b1;
        host_pwr_good = 1'b1; sw_enable = 1'b1;
        bring_up(cyc + 1, 2);
        repeat (TO - 1) step();
        n_checks++;
        if (rail_en !== 3'b011 || fault_n !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_early: got en=%b fn=%b expected en=011 fn=1", rail_en, fault_n);
        end
        step();
        n_checks++;
        if ({rail_en, fault_n, pod_ready, fault_rail} !== {3'b000, 1'b0, 1'b0, 2'd1}) begin
            n_errors++;
            $display("FAIL timeout_fault: got en=%b fn=%b rdy=%b fr=%0d expected en=000 fn=0 rdy=0 fr=1",
                     rail_en, fault_n, pod_ready, fault_rail);
        end
        repeat (5) step();
        n_checks++;
        if (fault_n !== 1'b0 || fault_rail !== 2'd1) begin
            n_errors++;
            $display("FAIL timeout_hold: got fn=%b fr=%0d expected fn=0 fr=1", fault_n, fault_rail);
        end
        host_pwr_good = 1'b0;
        blocked[1] = 1'b0;
        step();
        n_checks++;
        if (fault_n !== 1'b1 || rail_en !== 3'b000) begin
            n_errors++;
            $display("FAIL timeout_clear: got fn=%b en=%b expected fn=1 en=000", fault_n, rail_en);
        end
        host_pwr_good = 1'b1;
        bring_up(cyc + 1, 1);
    endtask

    task automatic test_glitch();
        for (int it = 0; it < 3; it++) begin
            int g, mask, exp_r;
            bit flt;
            do_reset();
            host_pwr_good = 1'b1; sw_enable = 1'b1;
            bring_up(cyc + 1, NR);
            if (GD > 0) begin
                int r;
                r = $urandom_range(0, NR - 1);
                g = $urandom_range(1, FL - 1);
                glitch_left[r] = g; rail_pg[r] = 1'b0;
                flt = 1'b0;
                repeat (FL + 4) begin
                    step();
                    if (!fault_n) flt = 1'b1;
                end
                n_checks++;
                if (flt !== 1'b0 || pod_ready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL glitch_short rail=%0d len=%0d: fault taken, rdy=%b, expected no fault", r, g, pod_ready);
                end
            end
            mask = $urandom_range(1, 7);
            g = (GD > 0) ? FL + $urandom_range(0, 3) : $urandom_range(1, 3);
            exp_r = -1;
            for (int k = NR - 1; k >= 0; k--) begin
                if (mask[k]) begin
                    exp_r = k; glitch_left[k] = g; rail_pg[k] = 1'b0;
                end
            end
            repeat (GD) step();
            n_checks++;
            if (fault_n !== 1'b1) begin
                n_errors++;
                $display("FAIL glitch_early mask=%b: got fn=%b expected 1", mask[2:0], fault_n);
            end
            step();
            n_checks++;
            if ({rail_en, fault_n, pod_ready, fault_rail} !== {3'b000, 1'b0, 1'b0, 2'(exp_r)}) begin
                n_errors++;
                $display("FAIL glitch_fault mask=%b len=%0d: got en=%b fn=%b rdy=%b fr=%0d expected en=000 fn=0 rdy=0 fr=%0d",
                         mask[2:0], g, rail_en, fault_n, pod_ready, fault_rail, exp_r);
            end
            host_pwr_good = 1'b0;
            step();
            n_checks++;
            if (fault_n !== 1'b1) begin
                n_errors++;
                $display("FAIL glitch_clear: got fn=%b expected 1", fault_n);
            end
        end
    endtask

    task automatic test_shutdown();
        do_reset();
        host_pwr_good = 1'b1; sw_enable = 1'b1;
        bring_up(cyc + 1, NR);
        sw_enable = 1'b0;
        step();
        n_checks++;
        if (rail_en !== 3'b011 || pod_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL down_first: got en=%b rdy=%b expected en=011 rdy=0", rail_en, pod_ready);
        end
        repeat (SC - 1) step();
        n_checks++;
        if (rail_en !== 3'b011) begin
            n_errors++;
            $display("FAIL down_hold1: got en=%b expected 011", rail_en);
        end
        step();
        n_checks++;
        if (rail_en !== 3'b001) begin
            n_errors++;
            $display("FAIL down_second: got en=%b expected 001", rail_en);
        end
        repeat (4) step();
        sw_enable = 1'b1;   // must be ignored until IDLE
        repeat (SC - 5) step();
        n_checks++;
        if (rail_en !== 3'b001) begin
            n_errors++;
            $display("FAIL down_hold2: got en=%b expected 001", rail_en);
        end
        step();
        n_checks++;
        if (rail_en !== 3'b000 || fault_n !== 1'b1) begin
            n_errors++;
            $display("FAIL down_last: got en=%b fn=%b expected en=000 fn=1", rail_en, fault_n);
        end
        bring_up(cyc + 1, 1);
    endtask

    task automatic test_host_loss();
        int d;
        bit bad;
        do_reset();
        lat[1] = $urandom_range(35, 60);
        host_pwr_good = 1'b1; sw_enable = 1'b1;
        bring_up(cyc + 1, 2);
        d = $urandom_range(0, 30);
        repeat (d) step();
        n_checks++;
        if (rail_en !== 3'b011) begin
            n_errors++;
            $display("FAIL hostloss_ramp d=%0d: got en=%b expected 011", d, rail_en);
        end
        host_pwr_good = 1'b0;
        step();
        n_checks++;
        if ({rail_en, fault_n, pod_ready} !== {3'b000, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL hostloss_drop: got en=%b fn=%b rdy=%b expected en=000 fn=1 rdy=0", rail_en, fault_n, pod_ready);
        end
        // Host loss coinciding with a rail drop in UP: no fault reported.
        host_pwr_good = 1'b1;
        bring_up(cyc + 1, NR);
        glitch_left[0] = FL + 2; rail_pg[0] = 1'b0;
        repeat (GD) step();
        host_pwr_good = 1'b0;
        step();
        bad = (rail_en !== 3'b000) || (fault_n !== 1'b1);
        repeat (5) begin
            step();
            if (fault_n !== 1'b1) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_errors++;
            $display("FAIL hostloss_vs_fault: got en=%b fn=%b expected en=000 fn=1", rail_en, fault_n);
        end
    endtask

    task automatic test_sw_vs_fault();
        do_reset();
        host_pwr_good = 1'b1; sw_enable = 1'b1;
        bring_up(cyc + 1, NR);
        glitch_left[2] = FL + 2; rail_pg[2] = 1'b0;
        repeat (GD) step();
        sw_enable = 1'b0;
        step();
        n_checks++;
        if ({rail_en, fault_n, fault_rail} !== {3'b000, 1'b0, 2'd2}) begin
            n_errors++;
            $display("FAIL sw_vs_fault: got en=%b fn=%b fr=%0d expected en=000 fn=0 fr=2", rail_en, fault_n, fault_rail);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        host_pwr_good = 1'b1; sw_enable = 1'b1;
        bring_up(cyc + 1, NR);
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({rail_en, fault_n, pod_ready, fault_rail} !== {3'b000, 1'b1, 1'b0, 2'd0}) begin
            n_errors++;
            $display("FAIL reset_mid: got en=%b fn=%b rdy=%b fr=%0d expected en=000 fn=1 rdy=0 fr=0",
                     rail_en, fault_n, pod_ready, fault_rail);
        end
        rst_n = 1'b1;
        bring_up(cyc + 1, 1);
    endtask

    initial begin
        cyc = 0; n_checks = 0; n_errors = 0;
        test_reset();
        test_nominal();
        test_timeout();
        test_glitch();
        test_shutdown();
        test_host_loss();
        test_sw_vs_fault();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
